segre_id_instr_buffer: RTL and testbench
========================================

Name: segre_id_instr_buffer

Overview:
Parametrised successor of the IF/ID decoupling register. The single-entry hold/inject-NOP flop becomes a DEPTH-entry instruction FIFO with valid/ready handshakes on both sides, a flush, and an N-source operand bypass network. It sits between the IF stage and the decoder. Its head entry feeds ID, and it selects the ID source operands from the RF read data or any of N_BYP bypass sources.

Parameters:
WORD_SIZE, 32, instruction/data width
ADDR_SIZE, 32, PC width
DEPTH, 4, FIFO entries; power of two, >=2
N_BYP, 3, number of bypass data sources (EX, MEM, WB by default)
SEL_W, $clog2(N_BYP+1), bypass select width (derived, do not override)

Ports:
clk_i  in  1  clock
rsn_i  in  1  reset, asynchronous, active-low
if_valid_i  in  1  IF presents an instruction
if_ready_o  out  1  buffer can accept this cycle
if_instr_i  in  WORD_SIZE  fetched instruction
if_pc_i  in  ADDR_SIZE  fetched PC
flush_i  in  1  drop all entries (controller NOP injection / redirect)
id_ready_i  in  1  ID consumes head (inverse of stage block)
id_valid_o  out  1  head entry is valid
id_instr_o  out  WORD_SIZE  head instruction, NOP when empty
id_pc_o  out  ADDR_SIZE  head PC
count_o  out  $clog2(DEPTH+1)  occupancy
finish_test_o  out  1  head is valid and equals 32'hfff01073
rf_data_a_i, rf_data_b_i  in  WORD_SIZE  RF read data
byp_data_i  in  N_BYP*WORD_SIZE  bypass data; source k occupies bits [k*WORD_SIZE +: WORD_SIZE]
byp_sel_a_i, byp_sel_b_i  in  SEL_W  0 = RF, k = byp source k-1
src_a_o, src_b_o  out  WORD_SIZE  muxed operands

Behaviour:
- Reset (async assert, sync deassert into logic):
  - head/tail pointers = 0, count = 0.
  - id_valid_o = 0, id_instr_o = NOP_INSTR (32'h00000013), id_pc_o = 32'hfffffffc.
  - finish_test_o = 0, if_ready_o = 1.
- push = if_valid_i & if_ready_o. Write at tail; tail increments modulo DEPTH, wrapping DEPTH-1 -> 0.
- pop = id_valid_o & id_ready_i. Head increments modulo DEPTH.
- if_ready_o = (count != DEPTH) and depends only on state. When full, a push is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Without the optional feature, a push into an empty buffer appears at id_valid_o one cycle later.
- id_valid_o = (count != 0). id_instr_o and id_pc_o come combinationally from the head entry.
- When empty: id_instr_o = NOP_INSTR and id_pc_o = PC of the last popped or flushed head entry (register last_pc, reset 32'hfffffffc).
- flush_i has highest priority:
  - Next cycle: count = 0, pointers = 0, last_pc = current head PC if nonempty, else unchanged.
  - A push and pop in the flush cycle are both discarded; id_ready_i is ignored.
- id_ready_i low holds the head; contents are stable (replaces block).
- Bypass mux is purely combinational: sel 0 or sel > N_BYP selects the RF data; sel k in 1..N_BYP selects byp_data_i source k-1. Operands A and B are independent.
- finish_test_o is combinational from the head entry and gated by id_valid_o.
- Entry storage is never reset; only pointers, count, and last_pc are reset.

Optional Feature:
SEGRE_ID_BUF_BYPASS_EN
- Defined: when count == 0, if_valid_i = 1, and flush_i = 0, if_instr_i/if_pc_i are forwarded combinationally to id_*_o with id_valid_o = 1.
  - If id_ready_i is also 1, the entry is consumed that cycle and is not written (count stays 0).
  - Otherwise it is written normally.
  - Zero-latency path.
- Undefined: minimum latency is 1 cycle, as above.

Test Plan:
- Reset with rsn_i low mid-cycle -> outputs immediately id_valid_o=0, id_instr_o=32'h00000013, id_pc_o=32'hfffffffc, count_o=0, if_ready_o=1.
- Push PCs 0x0,0x4,0x8,0xC with id_ready_i=0 (DEPTH=4) -> count_o=4, if_ready_o=0, id_pc_o=0x0. Then push attempt with id_ready_i=1 -> only pop; next cycle count_o=3, id_pc_o=0x4.
- Stream 10 instructions with continuous push/pop -> count_o constant, pointers wrap, id_pc_o sequence 0x0..0x24 in order with no loss or duplication.
- count_o=3 with head PC 0x40, flush_i=1 with simultaneous push -> next cycle count_o=0, id_valid_o=0, id_instr_o=NOP, id_pc_o=0x40.
- byp_data_i={W=0xCCCC,M=0xBBBB,E=0xAAAA}, rf_data_a_i=0x1111: sel_a=0/1/2/3 -> src_a_o=0x1111/0xAAAA/0xBBBB/0xCCCC; with sel_b=3 -> src_b_o=0xCCCC.
- Push 32'hfff01073 into an empty buffer -> finish_test_o=1 the next cycle (same cycle with SEGRE_ID_BUF_BYPASS_EN); 0 after pop or flush.

Source files
------------

// File: rtl/segre_id_instr_buffer.sv
// segre_id_instr_buffer
//
// Instruction FIFO between the IF stage and the decoder. It has valid/ready
// handshakes on both sides and a flush. It also contains the source-operand
// bypass mux for ID.
//
// Optional feature macro: SEGRE_ID_BUF_BYPASS_EN
//   When defined, the buffer is empty, IF is valid and no flush is active,
//   the fetched instruction is forwarded combinationally to ID. If ID takes
//   it in the same cycle, it is never written into the FIFO.
//
// Ports:
//   clk_i, rsn_i              clock, asynchronous active-low reset
//   if_valid_i / if_ready_o   IF-side handshake
//   if_instr_i, if_pc_i       fetched instruction and PC
//   flush_i                   drop all entries; highest priority
//   id_ready_i / id_valid_o   ID-side handshake on the head entry
//   id_instr_o, id_pc_o       head entry (NOP and last head PC when empty)
//   count_o                   occupancy
//   finish_test_o             valid head is the end-of-test instruction
//   rf_data_a_i, rf_data_b_i  register file read data
//   byp_data_i                N_BYP packed bypass sources; source k at [k*WORD_SIZE +: WORD_SIZE]
//   byp_sel_a_i, byp_sel_b_i  0 selects RF, k selects bypass source k-1
//   src_a_o, src_b_o          muxed operands
module segre_id_instr_buffer #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned N_BYP     = 3,
  parameter int unsigned SEL_W     = $clog2(N_BYP + 1)
) (
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         if_valid_i,
  output logic                         if_ready_o,
  input  logic [WORD_SIZE-1:0]         if_instr_i,
  input  logic [ADDR_SIZE-1:0]         if_pc_i,
  input  logic                         flush_i,
  input  logic                         id_ready_i,
  output logic                         id_valid_o,
  output logic [WORD_SIZE-1:0]         id_instr_o,
  output logic [ADDR_SIZE-1:0]         id_pc_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         finish_test_o,
  input  logic [WORD_SIZE-1:0]         rf_data_a_i,
  input  logic [WORD_SIZE-1:0]         rf_data_b_i,
  input  logic [N_BYP*WORD_SIZE-1:0]   byp_data_i,
  input  logic [SEL_W-1:0]             byp_sel_a_i,
  input  logic [SEL_W-1:0]             byp_sel_b_i,
  output logic [WORD_SIZE-1:0]         src_a_o,
  output logic [WORD_SIZE-1:0]         src_b_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [WORD_SIZE-1:0] NopInstr    = WORD_SIZE'(32'h0000_0013);
  localparam logic [WORD_SIZE-1:0] FinishInstr = WORD_SIZE'(32'hfff0_1073);
  localparam logic [ADDR_SIZE-1:0] ResetPc     = ADDR_SIZE'(32'hffff_fffc);

  // Entry storage; deliberately has no reset.
  logic [WORD_SIZE-1:0] instr_mem [DEPTH];
  logic [ADDR_SIZE-1:0] pc_mem    [DEPTH];

  logic [PtrW-1:0]      head_q, head_d;
  logic [PtrW-1:0]      tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [ADDR_SIZE-1:0] last_pc_q, last_pc_d;

  logic                 empty, full;
  logic                 fwd;
  logic                 push, pop;
  logic                 wr_en, rd_en;
  logic [WORD_SIZE-1:0] head_instr;
  logic [ADDR_SIZE-1:0] head_pc;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CntW'(DEPTH));
  assign head_instr = instr_mem[head_q];
  assign head_pc    = pc_mem[head_q];

`ifdef SEGRE_ID_BUF_BYPASS_EN
  assign fwd = empty & if_valid_i & ~flush_i;
`else
  assign fwd = 1'b0;
`endif

  // The ready signal depends only on state. A full buffer refuses a push even when it pops.
  assign if_ready_o = ~full;
  assign count_o    = count_q;
  assign id_valid_o = ~empty | fwd;

  assign push  = if_valid_i & if_ready_o & ~flush_i;
  assign pop   = id_valid_o & id_ready_i & ~flush_i;
  // A forwarded instruction that ID consumes in the same cycle never occupies an entry.
  assign wr_en = push & ~(fwd & pop);
  assign rd_en = pop & ~fwd;

  always_comb begin
    id_instr_o = NopInstr;
    id_pc_o    = last_pc_q;
    if (fwd) begin
      id_instr_o = if_instr_i;
      id_pc_o    = if_pc_i;
    end else if (!empty) begin
      id_instr_o = head_instr;
      id_pc_o    = head_pc;
    end
  end

  assign finish_test_o = id_valid_o & (id_instr_o == FinishInstr);

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    last_pc_d = last_pc_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      if (!empty) begin
        last_pc_d = head_pc;
      end
    end else begin
      if (wr_en) begin
        tail_d = tail_q + PtrW'(1);
      end
      if (rd_en) begin
        head_d = head_q + PtrW'(1);
      end
      if (pop) begin
        last_pc_d = id_pc_o;
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      last_pc_q <= ResetPc;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      instr_mem[tail_q] <= if_instr_i;
      pc_mem[tail_q]    <= if_pc_i;
    end
  end

  // Out-of-range selects fall back to the RF data.
  always_comb begin
    src_a_o = rf_data_a_i;
    src_b_o = rf_data_b_i;
    for (int unsigned k = 1; k <= N_BYP; k++) begin
      if (byp_sel_a_i == SEL_W'(k)) begin
        src_a_o = byp_data_i[(k-1)*WORD_SIZE +: WORD_SIZE];
      end
      if (byp_sel_b_i == SEL_W'(k)) begin
        src_b_o = byp_data_i[(k-1)*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

endmodule

// File: tb/tb_segre_id_instr_buffer.sv
module tb_segre_id_instr_buffer;

  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam logic [31:0] Fin = 32'hfff0_1073;
`ifdef SEGRE_ID_BUF_BYPASS_EN
  localparam bit ByP = 1'b1;
`else
  localparam bit ByP = 1'b0;
`endif
  // Steady occupancy while streaming with one push and one pop per cycle.
  localparam logic [2:0] Steady = ByP ? 3'd0 : 3'd1;

  logic        clk;
  logic        rsn;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  count;
  logic        finish_test;
  logic [31:0] rf_a, rf_b;
  logic [95:0] byp_data;
  logic [1:0]  sel_a, sel_b;
  logic [31:0] src_a, src_b;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  segre_id_instr_buffer dut (
    .clk_i         (clk),
    .rsn_i         (rsn),
    .if_valid_i    (if_valid),
    .if_ready_o    (if_ready),
    .if_instr_i    (if_instr),
    .if_pc_i       (if_pc),
    .flush_i       (flush),
    .id_ready_i    (id_ready),
    .id_valid_o    (id_valid),
    .id_instr_o    (id_instr),
    .id_pc_o       (id_pc),
    .count_o       (count),
    .finish_test_o (finish_test),
    .rf_data_a_i   (rf_a),
    .rf_data_b_i   (rf_b),
    .byp_data_i    (byp_data),
    .byp_sel_a_i   (sel_a),
    .byp_sel_b_i   (sel_b),
    .src_a_o       (src_a),
    .src_b_o       (src_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return 32'h0000_0093 | (pc << 20);
  endfunction

  task automatic apply(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    if_valid = v;
    if_pc    = pc;
    if_instr = ins;
    id_ready = rdy;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if_valid = 1'b0;
    id_ready = 1'b0;
    flush    = 1'b0;
  endtask

  // Scoreboard monitor: every accepted head entry must match the next expected one.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rsn && id_valid && id_ready && !flush) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pop: got pc %h instr %h expected no pop", id_pc, id_instr);
        end else begin
          e = exp_q.pop_front();
          check("pop_order", {id_instr, id_pc}, e);
        end
      end
    end
  end

  initial begin
    logic [31:0] exp_a [4];
    exp_a = '{32'h1111, 32'hAAAA, 32'hBBBB, 32'hCCCC};
    rsn = 1'b1;
    apply(1'b0, '0, '0, 1'b0, 1'b0);
    rf_a = '0; rf_b = '0; byp_data = '0; sel_a = '0; sel_b = '0;

    // Asynchronous reset asserted mid-cycle.
    @(posedge clk); #1;
    @(posedge clk); #2;
    rsn = 1'b0;
    #1;
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_id_instr", 64'(id_instr), 64'(Nop));
    check("rst_id_pc", 64'(id_pc), 64'hffff_fffc);
    check("rst_count", 64'(count), 64'd0);
    check("rst_if_ready", 64'(if_ready), 64'd1);
    check("rst_finish", 64'(finish_test), 64'd0);
    @(negedge clk);
    rsn = 1'b1;
    @(posedge clk); #1;

    // Fill to capacity while ID is stalled.
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 32'(4*i), mk(32'(4*i)), 1'b0, 1'b0);
      exp_q.push_back({mk(32'(4*i)), 32'(4*i)});
      tick();
    end
    check("full_count", 64'(count), 64'd4);
    check("full_if_ready", 64'(if_ready), 64'd0);
    check("full_id_pc", 64'(id_pc), 64'h0);
    // A push while full is refused even though a pop happens in the same cycle.
    apply(1'b1, 32'h10, mk(32'h10), 1'b1, 1'b0);
    tick();
    check("full_pop_count", 64'(count), 64'd3);
    check("full_pop_id_pc", 64'(id_pc), 64'h4);
    repeat (3) begin
      apply(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
    end
    check("drain_count", 64'(count), 64'd0);

    // Continuous streaming; pointers wrap twice.
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 32'(4*i), mk(32'(4*i)), 1'b1, 1'b0);
      exp_q.push_back({mk(32'(4*i)), 32'(4*i)});
      tick();
      check("stream_count", 64'(count), 64'(Steady));
    end
    apply(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("stream_end_count", 64'(count), 64'd0);

    // Flush with three entries and a simultaneous push and pop request.
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 32'(32'h40 + 4*i), mk(32'(32'h40 + 4*i)), 1'b0, 1'b0);
      tick();
    end
    check("preflush_count", 64'(count), 64'd3);
    check("preflush_id_pc", 64'(id_pc), 64'h40);
    apply(1'b1, 32'h4c, mk(32'h4c), 1'b1, 1'b1);
    tick();
    check("flush_count", 64'(count), 64'd0);
    check("flush_id_valid", 64'(id_valid), 64'd0);
    check("flush_id_instr", 64'(id_instr), 64'(Nop));
    check("flush_id_pc", 64'(id_pc), 64'h40);
    check("flush_if_ready", 64'(if_ready), 64'd1);

    // Bypass mux.
    rf_a = 32'h1111;
    rf_b = 32'h2222;
    byp_data = {32'hCCCC, 32'hBBBB, 32'hAAAA};
    sel_b = 2'd3;
    for (int s = 0; s < 4; s++) begin
      sel_a = 2'(s);
      #1;
      check("byp_src_a", 64'(src_a), 64'(exp_a[s]));
    end
    check("byp_src_b_wb", 64'(src_b), 64'hCCCC);
    sel_b = 2'd0;
    #1;
    check("byp_src_b_rf", 64'(src_b), 64'h2222);

    // End-of-test detection.
    apply(1'b1, 32'h80, Fin, 1'b0, 1'b0);
    exp_q.push_back({Fin, 32'h80});
    #1;
    check("finish_push_cycle", 64'(finish_test), 64'(ByP));
    tick();
    check("finish_next_cycle", 64'(finish_test), 64'd1);
    apply(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("finish_after_pop", 64'(finish_test), 64'd0);
    apply(1'b1, 32'h84, Fin, 1'b0, 1'b0);
    tick();
    check("finish_again", 64'(finish_test), 64'd1);
    apply(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    check("finish_after_flush", 64'(finish_test), 64'd0);
    check("flush_last_pc", 64'(id_pc), 64'h84);

    tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
